// File: rtl/shf_pkg.sv
// Shared types for the iterative LC-3b SHF unit: FSM states, shift ops and the ir[5:4] decoder.
`default_nettype none

package shf_pkg;

  localparam int AMT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LSHF  = 2'd0,
    OP_RSHFL = 2'd1,
    OP_RSHFA = 2'd2
  } op_t;

  // ir[5] only distinguishes the two right shifts; with ir[4]=0 it is a don't-care.
  function automatic op_t decode_op(input logic [1:0] f);
    op_t op;
    case (f)
      2'b01:   op = OP_RSHFL;
      2'b11:   op = OP_RSHFA;
      default: op = OP_LSHF;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shf_step.sv
// Combinational single shift step of 1 or 4 bit positions for the iterative SHF unit.
`default_nettype none

module shf_step
  import shf_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  op_t              op,
  input  logic             step4,
  output logic [WIDTH-1:0] stepped
);

  always_comb begin
    stepped = value;
    case (op)
      OP_LSHF:  stepped = step4 ? (value << 4) : (value << 1);
      OP_RSHFL: stepped = step4 ? (value >> 4) : (value >> 1);
      OP_RSHFA: stepped = step4 ? WIDTH'($signed(value) >>> 4)
                                : WIDTH'($signed(value) >>> 1);
      default:  stepped = value;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shf_iter.sv
// Multi-cycle LC-3b SHF unit (LSHF/RSHFL/RSHFA) with valid/ready handshakes.
// Define SHF_STEP4_EN to let a SHIFT cycle advance 4 bits while the remaining count is >= 4.
`default_nettype none

module shf_iter
  import shf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [5:0]       ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   amount;
  logic               step4;
  logic [WIDTH-1:0]   stepped;

  assign amount = ir[CNT_W-1:0];

`ifdef SHF_STEP4_EN
  assign step4 = (cnt_q >= CNT_W'(4));
`else
  assign step4 = 1'b0;
`endif

  shf_step #(.WIDTH(WIDTH)) u_step (
    .value   (val_q),
    .op      (op_q),
    .step4   (step4),
    .stepped (stepped)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          val_d   = a;
          op_d    = decode_op(ir[5:4]);
          cnt_d   = amount;
          state_d = (amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        val_d = stepped;
        cnt_d = cnt_q - (step4 ? CNT_W'(4) : CNT_W'(1));
        if (cnt_d == '0) state_d = DONE;
      end
      DONE: begin
        // Return to IDLE only; a new request is taken on a later cycle.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_LSHF;
      val_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = val_q;

endmodule

`default_nettype wire

// File: tb/tb_shf_iter.sv
// Scoreboard bench for shf_iter: directed vectors, monitor checks result and latency.
`default_nettype none

module tb_shf_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [5:0]  ir = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        busy;

  shf_iter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .ir        (ir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: latency on out_valid rise, result on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got result %0h expected no output", result);
        end else begin
          check("latency", cyc - q[0].acc + 1, q[0].lat);
        end
      end
      if (out_valid && out_ready && q.size() != 0) begin
        check("result", result, q[0].res);
        void'(q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [15:0] av, input logic [5:0] irv, input logic [15:0] res,
                       input int lat1, input int lat4);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    e.res = res;
`ifdef SHF_STEP4_EN
    e.lat = lat4;
`else
    e.lat = lat1;
`endif
    e.acc = cyc + 1;
    q.push_back(e);
    a = av;
    ir = irv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hDEAD;
    ir = 6'b111111;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  logic [15:0] held;

  initial begin
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 16'h0000);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    issue(16'h8001, 6'b000011, 16'h0008, 4, 4);
    drain();
    issue(16'h8000, 6'b110100, 16'hF800, 5, 2);
    drain();
    issue(16'h8000, 6'b010100, 16'h0800, 5, 2);
    drain();
    issue(16'h8000, 6'b100100, 16'h0000, 5, 2);
    drain();
    issue(16'h1234, 6'b010000, 16'h1234, 1, 1);
    drain();
    issue(16'hFFFF, 6'b001111, 16'h8000, 16, 7);
    drain();
    issue(16'hA5A5, 6'b110111, 16'hFF4B, 8, 5);
    drain();
    issue(16'h00F0, 6'b111111, 16'h0000, 16, 7);
    drain();

    // Backpressure in DONE
    out_ready = 1'b0;
    issue(16'h0F0F, 6'b010010, 16'h03C3, 3, 3);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("bp_valid", out_valid, 1);
    held = result;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        a = 16'h5555;
        ir = 6'b000001;
        in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_stable", result, held);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    drain();
    repeat (3) @(negedge clk);

    // Reset mid-SHIFT
    issue(16'h0001, 6'b001010, 16'h0400, 11, 5);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 16'h0000);
    check("midrst_busy", busy, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    issue(16'h0003, 6'b000010, 16'h000C, 3, 3);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
